// File: rtl/mcycle_pkg.sv
// Shared types and encodings for the multi-cycle multiply/divide unit.
package mcycle_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPUTE = 2'd1,
    S_DONE    = 2'd2
  } state_e;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

endpackage

// File: rtl/mcycle_unit.sv
// Iterative unsigned multiply / divide unit, one bit per cycle over WIDTH cycles.
// Both operations share one 2*WIDTH shift register and one WIDTH+1-bit adder.
module mcycle_unit
  import mcycle_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RESETn,
  input  logic             Start,
  input  logic             MCycleOp,
  input  logic [WIDTH-1:0] Operand1,
  input  logic [WIDTH-1:0] Operand2,
  output logic [WIDTH-1:0] Result1,
  output logic [WIDTH-1:0] Result2,
  output logic             Busy,
  output logic             Done
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
  localparam int unsigned ACC_W = 2 * WIDTH;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               op_q, op_d;
  logic [WIDTH-1:0]   result1_q, result1_d;
  logic [WIDTH-1:0]   result2_q, result2_d;

  logic               is_mul;
  logic [WIDTH:0]     add_a;
  logic [WIDTH:0]     add_b;
  logic               add_cin;
  logic [WIDTH+1:0]   add_sum;
  logic [ACC_W-1:0]   acc_step;

  assign is_mul = (op_q == OP_MUL);

  // Shared adder: multiply adds the multiplicand to the high half,
  // divide subtracts the divisor from the left-shifted partial remainder.
  always_comb begin
    add_a   = is_mul ? {1'b0, acc_q[ACC_W-1:WIDTH]} : acc_q[ACC_W-1:WIDTH-1];
    add_b   = is_mul ? {1'b0, b_q} : ~{1'b0, b_q};
    add_cin = ~is_mul;
    add_sum = {1'b0, add_a} + {1'b0, add_b} + (WIDTH+2)'(add_cin);
  end

  // One iteration of shift-add multiply or restoring divide.
  // A zero divisor never borrows, so it naturally yields all-ones / dividend.
  always_comb begin
    acc_step = acc_q;
    if (is_mul) begin
      if (acc_q[0]) begin
        acc_step = {add_sum[WIDTH:0], acc_q[WIDTH-1:1]};
      end else begin
        acc_step = {1'b0, acc_q[ACC_W-1:1]};
      end
    end else begin
      if (add_sum[WIDTH+1]) begin
        acc_step = {add_sum[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_step = {acc_q[ACC_W-2:0], 1'b0};
      end
    end
  end

  // Next-state, operand capture, iteration count and result update.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    b_d       = b_q;
    op_d      = op_q;
    result1_d = result1_q;
    result2_d = result2_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (Start) begin
          state_d = S_COMPUTE;
          cnt_d   = '0;
          op_d    = MCycleOp;
          if (MCycleOp == OP_MUL) begin
            b_d   = Operand1;
            acc_d = {{WIDTH{1'b0}}, Operand2};
          end else begin
            b_d   = Operand2;
            acc_d = {{WIDTH{1'b0}}, Operand1};
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_COMPUTE: begin
        acc_d = acc_step;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d   = S_DONE;
          cnt_d     = '0;
          result1_d = acc_step[WIDTH-1:0];
          result2_d = acc_step[ACC_W-1:WIDTH];
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      b_q       <= '0;
      op_q      <= OP_MUL;
      result1_q <= '0;
      result2_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      b_q       <= b_d;
      op_q      <= op_d;
      result1_q <= result1_d;
      result2_q <= result2_d;
    end
  end

  // Busy rises in the Start cycle so the pipeline stalls immediately.
  always_comb begin
    Busy = RESETn &&
           ((((state_q == S_IDLE) || (state_q == S_DONE)) && Start) ||
            (state_q == S_COMPUTE));
    Done = (state_q == S_DONE);
  end

  assign Result1 = result1_q;
  assign Result2 = result2_q;

endmodule

// File: tb/tb_mcycle_unit.sv
// Directed self-checking bench for mcycle_unit at WIDTH=32.
module tb_mcycle_unit;

  logic        CLK;
  logic        RESETn;
  logic        Start;
  logic        MCycleOp;
  logic [31:0] Operand1;
  logic [31:0] Operand2;
  logic [31:0] Result1;
  logic [31:0] Result2;
  logic        Busy;
  logic        Done;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] prev1  = 32'd0;
  logic [31:0] prev2  = 32'd0;

  mcycle_unit #(.WIDTH(32)) dut (
    .CLK      (CLK),
    .RESETn   (RESETn),
    .Start    (Start),
    .MCycleOp (MCycleOp),
    .Operand1 (Operand1),
    .Operand2 (Operand2),
    .Result1  (Result1),
    .Result2  (Result2),
    .Busy     (Busy),
    .Done     (Done)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Drive one cycle's inputs at the falling edge, then settle before sampling.
  task automatic cycle_in(input logic st, input logic op, input logic [31:0] a, input logic [31:0] b);
    @(negedge CLK);
    Start    = st;
    MCycleOp = op;
    Operand1 = a;
    Operand2 = b;
    #1;
  endtask

  task automatic test_reset();
    RESETn   = 1'b0;
    Start    = 1'b1;
    MCycleOp = 1'b0;
    Operand1 = 32'd5;
    Operand2 = 32'd5;
    #2;
    checks++;
    if (Busy !== 1'b0 || Done !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: Busy=%b Done=%b, want 0 0", Busy, Done);
    end
    checks++;
    if (Result1 !== 32'd0 || Result2 !== 32'd0) begin
      errors++;
      $display("FAIL reset_results: R1=%h R2=%h, want 0 0", Result1, Result2);
    end
    @(negedge CLK);
    Start  = 1'b0;
    RESETn = 1'b1;
    @(negedge CLK);
  endtask

  // Full operation from Start to the cycle after Done; glitch_at injects a
  // Start with different operands at that compute cycle (0 = none).
  task automatic run_op(input string nm, input logic op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] e1, input logic [31:0] e2, input int glitch_at);
    cycle_in(1'b1, op, a, b);
    checks++;
    if (Busy !== 1'b1 || Done !== 1'b0) begin
      errors++;
      $display("FAIL %s_c0: Busy=%b Done=%b, want 1 0", nm, Busy, Done);
    end
    for (int c = 1; c <= 32; c++) begin
      if (c == glitch_at) cycle_in(1'b1, ~op, 32'd3, 32'd3);
      else cycle_in(1'b0, 1'($urandom_range(0, 1)), $urandom, $urandom);
      checks++;
      if (Busy !== 1'b1 || Done !== 1'b0 || Result1 !== prev1 || Result2 !== prev2) begin
        errors++;
        $display("FAIL %s_c%0d: Busy=%b Done=%b R1=%h R2=%h, want 1 0 %h %h",
                 nm, c, Busy, Done, Result1, Result2, prev1, prev2);
      end
    end
    cycle_in(1'b0, op, a, b);
    checks++;
    if (Done !== 1'b1 || Busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_done: Done=%b Busy=%b, want 1 0", nm, Done, Busy);
    end
    checks++;
    if (Result1 !== e1) begin
      errors++;
      $display("FAIL %s_r1: got %h want %h", nm, Result1, e1);
    end
    checks++;
    if (Result2 !== e2) begin
      errors++;
      $display("FAIL %s_r2: got %h want %h", nm, Result2, e2);
    end
    prev1 = e1;
    prev2 = e2;
    cycle_in(1'b0, op, $urandom, $urandom);
    checks++;
    if (Done !== 1'b0 || Busy !== 1'b0 || Result1 !== prev1 || Result2 !== prev2) begin
      errors++;
      $display("FAIL %s_after: Done=%b Busy=%b R1=%h R2=%h, want 0 0 %h %h",
               nm, Done, Busy, Result1, Result2, prev1, prev2);
    end
  endtask

  task automatic test_mul();
    run_op("mul_7x6", 1'b0, 32'd7, 32'd6, 32'd42, 32'd0, 0);
    run_op("mul_max", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 0);
  endtask

  task automatic test_div();
    run_op("div_100_7", 1'b1, 32'd100, 32'd7, 32'd14, 32'd2, 10);
    run_op("div_by_zero", 1'b1, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 0);
  endtask

  task automatic test_reset_abort();
    cycle_in(1'b1, 1'b0, 32'd9, 32'd9);
    for (int c = 1; c <= 9; c++) cycle_in(1'b0, 1'b0, 32'd9, 32'd9);
    @(negedge CLK);
    RESETn = 1'b0;
    Start  = 1'b1;
    #1;
    checks++;
    if (Busy !== 1'b0 || Done !== 1'b0) begin
      errors++;
      $display("FAIL abort_flags: Busy=%b Done=%b, want 0 0", Busy, Done);
    end
    checks++;
    if (Result1 !== 32'd0 || Result2 !== 32'd0) begin
      errors++;
      $display("FAIL abort_results: R1=%h R2=%h, want 0 0", Result1, Result2);
    end
    @(negedge CLK);
    #1;
    checks++;
    if (Busy !== 1'b0 || Done !== 1'b0) begin
      errors++;
      $display("FAIL abort_hold: Busy=%b Done=%b, want 0 0", Busy, Done);
    end
    @(negedge CLK);
    Start  = 1'b0;
    RESETn = 1'b1;
    prev1  = 32'd0;
    prev2  = 32'd0;
    run_op("mul_3x4", 1'b0, 32'd3, 32'd4, 32'd12, 32'd0, 0);
  endtask

  task automatic test_back_to_back();
    cycle_in(1'b1, 1'b0, 32'd2, 32'd3);
    for (int c = 1; c <= 32; c++) cycle_in(1'b0, 1'b0, 32'd2, 32'd3);
    cycle_in(1'b1, 1'b1, 32'd9, 32'd2);
    checks++;
    if (Done !== 1'b1 || Busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_mul_done: Done=%b Busy=%b, want 1 1", Done, Busy);
    end
    checks++;
    if (Result1 !== 32'd6 || Result2 !== 32'd0) begin
      errors++;
      $display("FAIL b2b_mul_res: R1=%h R2=%h, want 6 0", Result1, Result2);
    end
    for (int c = 1; c <= 32; c++) begin
      cycle_in(1'b0, 1'b0, 32'd1, 32'd1);
      checks++;
      if (Done !== 1'b0 || Busy !== 1'b1 || Result1 !== 32'd6 || Result2 !== 32'd0) begin
        errors++;
        $display("FAIL b2b_div_c%0d: Done=%b Busy=%b R1=%h R2=%h, want 0 1 6 0",
                 c, Done, Busy, Result1, Result2);
      end
    end
    cycle_in(1'b0, 1'b0, 32'd1, 32'd1);
    checks++;
    if (Done !== 1'b1 || Busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_div_done: Done=%b Busy=%b, want 1 0", Done, Busy);
    end
    checks++;
    if (Result1 !== 32'd4 || Result2 !== 32'd1) begin
      errors++;
      $display("FAIL b2b_div_res: R1=%h R2=%h, want 4 1", Result1, Result2);
    end
    cycle_in(1'b0, 1'b0, 32'd1, 32'd1);
    checks++;
    if (Done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_single_pulse: Done=%b, want 0", Done);
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_reset_abort();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
